// File: rtl/aes_keyram_multi.sv
// Multi-context AES round-key store: SLOTS independent key schedules, loaded by a word stream, read by (slot, word).
// Latency: a load word is written on the accepting edge; reads return one cycle after rd_en; ld_done one cycle after the last word.
// Backpressure: ld_ready is high only while a load is in progress; reads are never stalled and are rejected (rd_err) for invalid slot/address.
//
// Ports: clk/kill_n (async reset)/kill (sync flush); load side ld_start/ld_slot/ld_mode begin a schedule,
// ld_valid/ld_data/ld_ready stream its words, ld_done/ld_err report completion or a reserved mode;
// read side rd_en/rd_slot/rd_addr -> rd_data/rd_valid/rd_err; slot_valid flags complete schedules.
// SLOTS is expected to be a power of two so every rd_slot value names a real slot.
module aes_keyram_multi #(
  parameter int DATA_W     = 64,
  parameter int SLOTS      = 4,
  parameter int SLOT_DEPTH = 32,
  localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              kill_n,
  input  logic              kill,
  input  logic              ld_start,
  input  logic [SLOT_W-1:0] ld_slot,
  input  logic [1:0]        ld_mode,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  input  logic              rd_en,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [SLOTS-1:0]  slot_valid
);

  localparam int MEM_AW = $clog2(SLOTS * SLOT_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Schedule length in 64-bit half-round-key words for each key size.
  function automatic logic [ADDR_W-1:0] words_for(input logic [1:0] mode);
    case (mode)
      2'b00:   return 5'd22;
      2'b01:   return 5'd26;
      default: return 5'd30;
    endcase
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [SLOT_W-1:0] cur_slot;
  logic [1:0]        slot_mode [SLOTS];
  logic [DATA_W-1:0] mem [SLOTS*SLOT_DEPTH];

  logic              wr_en;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;
  logic              rd_ok;
  logic [ADDR_W-1:0] cur_n;

  // kill gates the handshake outputs in the same cycle so no word is taken
  // and no completion is reported while a flush is being applied.
  assign ld_ready = (state == S_LOAD) && !kill;
  assign ld_done  = (state == S_DONE) && !kill;
  assign wr_en    = ld_ready && ld_valid;

  assign wr_idx = MEM_AW'(cur_slot) * MEM_AW'(SLOT_DEPTH) + MEM_AW'(cnt);
  assign rd_idx = MEM_AW'(rd_slot)  * MEM_AW'(SLOT_DEPTH) + MEM_AW'(rd_addr);
  assign cur_n  = words_for(slot_mode[cur_slot]);
  // A slot under load has its valid bit cleared, so reads of it are rejected here.
  assign rd_ok  = slot_valid[rd_slot] && (rd_addr < words_for(slot_mode[rd_slot]));

  // Key storage carries no reset; validity is tracked by slot_valid alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cur_slot   <= '0;
      slot_valid <= '0;
      ld_err     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_mode[i] <= 2'b00;
      end
    end else if (kill) begin
      // The slot being loaded was already invalidated at ld_start and stays so.
      state    <= S_IDLE;
      cnt      <= '0;
      ld_err   <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      ld_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_start) begin
            if (ld_mode == 2'b11) begin
              ld_err <= 1'b1;
            end else begin
              state               <= S_LOAD;
              cur_slot            <= ld_slot;
              slot_mode[ld_slot]  <= ld_mode;
              cnt                 <= '0;
              slot_valid[ld_slot] <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            if (cnt == cur_n - 5'd1) begin
              state <= S_DONE;
            end
            cnt <= cnt + 5'd1;
          end
        end
        S_DONE: begin
          slot_valid[cur_slot] <= 1'b1;
          state                <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Read port: data/err hold their last value while rd_en is low.
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_err  <= !rd_ok;
        rd_data <= rd_ok ? mem[rd_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_aes_keyram_multi.sv
// Directed bench for aes_keyram_multi: loads, reads, reserved mode, kill and async reset.
module tb_aes_keyram_multi;

  logic        clk = 1'b0;
  logic        kill_n;
  logic        kill;
  logic        ld_start;
  logic [1:0]  ld_slot;
  logic [1:0]  ld_mode;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_err;
  logic        rd_en;
  logic [1:0]  rd_slot;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic [3:0]  slot_valid;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  aes_keyram_multi dut (
    .clk(clk), .kill_n(kill_n), .kill(kill),
    .ld_start(ld_start), .ld_slot(ld_slot), .ld_mode(ld_mode),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_err(ld_err),
    .rd_en(rd_en), .rd_slot(rd_slot), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .slot_valid(slot_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word i of a schedule: byte j = seed + 8*i + j (seed 0 gives 0706050403020100, 0f0e0d0c0b0a0908, ...).
  function automatic logic [63:0] pat(input logic [7:0] seed, input int i);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = seed + 8'(8*i + j);
    return w;
  endfunction

  // Single read at the next edge; results checked at the following negedge.
  task automatic rd_chk(input logic [1:0] s, input int a, input logic [63:0] d,
                        input logic e, input string tag);
    rd_en = 1'b1; rd_slot = s; rd_addr = 5'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, "_data"},  rd_data, d);
    chk({tag, "_err"},   64'(rd_err), 64'(e));
  endtask

  // Start a load and stream nw words. gap: ld_valid every other cycle.
  // rd_on: read slot 0 (seed rseed, rn words) every cycle and inject an ignored ld_start.
  task automatic load(input logic [1:0] slot, input logic [1:0] mode, input logic [7:0] seed,
                      input int nw, input logic gap, input logic rd_on,
                      input logic [7:0] rseed, input int rn, input logic done);
    int k = 0;
    int cyc = 0;
    logic tog = 1'b0;
    logic drv;
    logic rdy;
    logic [4:0] ra = 5'd0;
    ld_start = 1'b1; ld_slot = slot; ld_mode = mode;
    @(negedge clk);
    ld_start = 1'b0;
    while (k < nw && cyc < 400) begin
      rdy = ld_ready;
      drv = !(gap && tog);
      ld_valid = drv;
      if (drv) ld_data = pat(seed, k);
      if (rd_on) begin
        rd_en = 1'b1; rd_slot = 2'd0; rd_addr = ra;
        ld_start = (cyc == 5);
        if (cyc == 5) begin ld_slot = 2'd0; ld_mode = 2'b00; end
      end
      @(negedge clk);
      ld_start = 1'b0;
      cyc++;
      tog = !tog;
      if (drv && rdy) k++;
      if (rd_on) begin
        chk("bg_rd_valid", 64'(rd_valid), 64'd1);
        chk("bg_rd_data", rd_data, pat(rseed, int'(ra)));
        chk("bg_rd_err", 64'(rd_err), 64'd0);
        ra = (int'(ra) == rn - 1) ? 5'd0 : ra + 5'd1;
      end
    end
    ld_valid = 1'b0; rd_en = 1'b0;
    chk("ld_count", 64'(k), 64'(nw));
    if (done) begin
      chk("ld_done_hi", 64'(ld_done), 64'd1);
      chk("ld_ready_done", 64'(ld_ready), 64'd0);
      @(negedge clk);
      chk("ld_done_lo", 64'(ld_done), 64'd0);
    end
  endtask

  initial begin
    kill_n = 1'b1; kill = 1'b0; ld_start = 1'b0; ld_slot = 2'd0; ld_mode = 2'b00;
    ld_valid = 1'b0; ld_data = '0; rd_en = 1'b0; rd_slot = 2'd0; rd_addr = 5'd0;
    #2 kill_n = 1'b0;
    #10;
    chk("rst_slot_valid", 64'(slot_valid), 64'h0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_ld_done", 64'(ld_done), 64'd0);
    chk("rst_ld_err", 64'(ld_err), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_err", 64'(rd_err), 64'd0);
    chk("rst_rd_data", rd_data, 64'h0);
    @(negedge clk);
    kill_n = 1'b1;
    @(negedge clk);

    // Read of an unloaded slot, then hold behaviour with rd_en low.
    rd_chk(2'd3, 0, 64'h0, 1'b1, "unloaded");
    @(negedge clk);
    chk("idle_rd_valid", 64'(rd_valid), 64'd0);
    chk("hold_rd_err", 64'(rd_err), 64'd1);

    // Slot 2, 128-bit schedule.
    load(2'd2, 2'b00, 8'h00, 22, 1'b0, 1'b0, 8'h00, 1, 1'b1);
    chk("sv_after_s2", 64'(slot_valid), 64'h4);
    rd_chk(2'd2, 1, 64'h0f0e0d0c0b0a0908, 1'b0, "s2_w1");
    rd_chk(2'd2, 21, pat(8'h00, 21), 1'b0, "s2_w21");
    rd_chk(2'd2, 22, 64'h0, 1'b1, "s2_a22");
    rd_chk(2'd2, 0, 64'h0706050403020100, 1'b0, "s2_w0");
    @(negedge clk);
    chk("hold_rd_data", rd_data, 64'h0706050403020100);
    chk("hold_rd_valid", 64'(rd_valid), 64'd0);

    // Reserved key size.
    ld_start = 1'b1; ld_slot = 2'd2; ld_mode = 2'b11;
    @(negedge clk);
    ld_start = 1'b0;
    chk("rsv_ld_err", 64'(ld_err), 64'd1);
    chk("rsv_ld_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    chk("rsv_ld_err_lo", 64'(ld_err), 64'd0);
    chk("rsv_ld_ready2", 64'(ld_ready), 64'd0);
    chk("rsv_slot_valid", 64'(slot_valid), 64'h4);

    // Slot 0, then 256-bit slot 3 with gaps while slot 0 is read every cycle.
    load(2'd0, 2'b00, 8'h40, 22, 1'b0, 1'b0, 8'h00, 1, 1'b1);
    load(2'd3, 2'b10, 8'h90, 30, 1'b1, 1'b1, 8'h40, 22, 1'b1);
    @(negedge clk);
    chk("sv_after_s3", 64'(slot_valid), 64'hd);
    for (int a = 0; a < 30; a++) rd_chk(2'd3, a, pat(8'h90, a), 1'b0, "s3_rd");
    rd_chk(2'd3, 30, 64'h0, 1'b1, "s3_a30");

    // Kill part-way through a 192-bit load of slot 1.
    load(2'd1, 2'b01, 8'h10, 10, 1'b0, 1'b0, 8'h00, 1, 1'b0);
    rd_chk(2'd0, 3, pat(8'h40, 3), 1'b0, "pre_kill");
    kill = 1'b1; rd_en = 1'b1; rd_slot = 2'd0; rd_addr = 5'd4;
    ld_valid = 1'b1; ld_data = 64'hdead_beef_0000_0000;
    #1 chk("kill_ld_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    kill = 1'b0; rd_en = 1'b0; ld_valid = 1'b0;
    chk("kill_rd_valid", 64'(rd_valid), 64'd0);
    chk("kill_rd_data", rd_data, 64'h0);
    chk("kill_rd_err", 64'(rd_err), 64'd0);
    chk("kill_idle_ready", 64'(ld_ready), 64'd0);
    chk("kill_slot_valid", 64'(slot_valid), 64'hd);
    rd_chk(2'd1, 0, 64'h0, 1'b1, "killed_s1");
    load(2'd1, 2'b01, 8'h80, 26, 1'b0, 1'b0, 8'h00, 1, 1'b1);
    @(negedge clk);
    chk("sv_after_s1", 64'(slot_valid), 64'hf);
    rd_chk(2'd1, 9, pat(8'h80, 9), 1'b0, "s1_w9");
    rd_chk(2'd1, 25, pat(8'h80, 25), 1'b0, "s1_w25");
    rd_chk(2'd1, 26, 64'h0, 1'b1, "s1_a26");

    // Asynchronous reset in the middle of a load, between clock edges.
    load(2'd2, 2'b00, 8'h20, 5, 1'b0, 1'b0, 8'h00, 1, 1'b0);
    rd_chk(2'd1, 0, pat(8'h80, 0), 1'b0, "pre_arst");
    #3 kill_n = 1'b0;
    #1;
    chk("arst_slot_valid", 64'(slot_valid), 64'h0);
    chk("arst_ld_ready", 64'(ld_ready), 64'd0);
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_rd_data", rd_data, 64'h0);
    chk("arst_rd_err", 64'(rd_err), 64'd0);
    @(negedge clk);
    kill_n = 1'b1;
    @(negedge clk);
    rd_chk(2'd0, 0, 64'h0, 1'b1, "arst_s0");
    load(2'd0, 2'b00, 8'h55, 22, 1'b0, 1'b0, 8'h00, 1, 1'b1);
    @(negedge clk);
    chk("sv_after_reload", 64'(slot_valid), 64'h1);
    rd_chk(2'd0, 7, pat(8'h55, 7), 1'b0, "s0_reload_w7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_keyram_multi.md
AES_KEYRAM_MULTI -- requirements
Module: aes_keyram_multi

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the half-round-key word width.
REQ-002 The block SHALL have parameter SLOTS, default 4, giving the number of independent key-schedule contexts; SLOT_W = clog2(SLOTS).
REQ-003 The block SHALL have parameter SLOT_DEPTH, default 32, giving words per slot; ADDR_W = 5.
REQ-004 Ports, in this order:
- clk  in  1  single clock, all logic on rising edge.
- kill_n  in  1  asynchronous active-low reset.
- kill  in  1  synchronous active-high flush.
- ld_start  in  1  begin a schedule load.
- ld_slot  in  SLOT_W  target slot.
- ld_mode  in  2  key size: 00=128, 01=192, 10=256, 11=reserved.
- ld_valid  in  1  ld_data qualifier.
- ld_data  in  DATA_W  schedule word.
- ld_ready  out  1  load word accepted this cycle when high with ld_valid.
- ld_done  out  1  one-cycle load-complete pulse.
- ld_err  out  1  one-cycle reserved-mode pulse.
- rd_en  in  1  read request.
- rd_slot  in  SLOT_W  read slot.
- rd_addr  in  ADDR_W  word index within slot.
- rd_data  out  DATA_W  read word.
- rd_valid  out  1  rd_data qualifier.
- rd_err  out  1  read rejected.
- slot_valid  out  SLOTS  per-slot schedule-complete flags.

Function
REQ-005 Storage SHALL be SLOTS*SLOT_DEPTH words of DATA_W; word (s,a) at linear index s*SLOT_DEPTH+a; storage contents SHALL NOT be reset.
REQ-006 Expected word count N per mode SHALL be 22 (128), 26 (192), 30 (256); each slot SHALL record its mode at load start.
REQ-007 Load FSM SHALL have states IDLE, LOAD, DONE.
REQ-008 IDLE: ld_start with ld_mode != 11 -> LOAD; capture slot/mode, clear word counter to 0, clear slot_valid[ld_slot] in the same edge.
REQ-009 IDLE: ld_start with ld_mode = 11 -> ld_err = 1 next cycle, stay IDLE, no slot_valid change.
REQ-010 ld_ready SHALL be 1 only in LOAD; each cycle with ld_valid & ld_ready writes ld_data to word (slot, counter) and increments counter.
REQ-011 Acceptance of word N-1 SHALL move LOAD -> DONE; ld_valid gaps SHALL stall without loss or duplication.
REQ-012 DONE SHALL last one cycle with ld_done = 1, set slot_valid[slot], then -> IDLE.
REQ-013 ld_start SHALL be ignored in LOAD and DONE.
REQ-014 Read latency SHALL be 1 cycle: rd_en at edge k gives rd_valid = 1 at edge k+1, rd_valid = 0 otherwise.
REQ-015 If slot_valid[rd_slot] = 1 and rd_addr < N(slot mode), rd_data SHALL be the stored word, rd_err = 0; else rd_data = 0, rd_err = 1.
REQ-016 rd_data and rd_err SHALL hold their last value when rd_en = 0.
REQ-017 A read of the slot being loaded SHALL be rejected per REQ-015; a read of another slot SHALL proceed concurrently with a load.
REQ-018 Reload of a valid slot SHALL invalidate it from the ld_start edge until its ld_done.

Reset
REQ-019 kill_n = 0 SHALL asynchronously force FSM IDLE, counter 0, slot_valid all 0, ld_ready/ld_done/ld_err/rd_valid/rd_err 0, rd_data 0.
REQ-020 kill = 1 SHALL synchronously force FSM IDLE and all outputs except slot_valid to 0; the slot under load stays invalid, other slot_valid bits are kept; kill has priority over ld_start, ld_valid and rd_en.

Verification
REQ-021 Load slot 2 mode 00 with 22 words, word0 = 64'h0706050403020100, word1 = 64'h0f0e0d0c0b0a0908 -> ld_done one cycle after 22nd accept, slot_valid = 4'b0100; read (2,1) -> next cycle rd_data = 64'h0f0e0d0c0b0a0908, rd_valid = 1, rd_err = 0.
REQ-022 Mode 00 slot read addr 22, and any read of an unloaded slot -> rd_data = 0, rd_err = 1, rd_valid = 1.
REQ-023 ld_start with ld_mode = 11 -> ld_err pulse, ld_ready stays 0, slot_valid unchanged.
REQ-024 Mode 10 load with ld_valid toggled every other cycle, plus back-to-back reads of valid slot 0 throughout -> exactly 30 words stored in order, slot 0 reads correct every cycle.
REQ-025 kill after 10 of 26 words (mode 01, slot 1) -> FSM IDLE, slot_valid[1] = 0, other bits kept; reload slot 1 fully -> correct data.
REQ-026 kill_n low mid-load, asynchronous to clk -> all outputs 0 immediately, slot_valid = 0 until reloads complete.
